lzc_seq_ctrl: RTL and testbench

Multi-cycle leading-zero counter for wide words. It sequences a single 4-bit leading-zero evaluation across the nibbles of a `4*NIBBLES`-bit operand, MSB nibble first, and stops at the first non-zero nibble. It sits beside the 4-bit LZC operator as its controller and serves normalization paths that can tolerate a few cycles of latency, using a start/busy/done handshake.

---
 rtl/lzc_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_lzc_seq_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lzc_seq_ctrl.sv
// lzc_seq_ctrl: multi-cycle leading-zero counter for a 4*NIBBLES-bit operand.
// It scans one nibble per cycle, MSB nibble first, and stops at the first
// non-zero nibble. The handshake is start/busy/done.
//
// Ports:
//   clk    - clock; all state changes on the rising edge
//   rst_n  - synchronous active-low reset
//   start  - request; sampled only in IDLE
//   din    - operand; captured on the edge that accepts start
//   busy   - high whenever the controller is not IDLE
//   done   - one-cycle pulse when count/zero are valid
//   count  - number of leading zeros, 0..WIDTH
//   zero   - operand was all zeros
module lzc_seq_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [4*NIBBLES-1:0]               din,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(4*NIBBLES+1)-1:0]     count,
  output logic                               zero
);

  localparam int unsigned WIDTH = 4 * NIBBLES;
  localparam int unsigned CW    = $clog2(WIDTH + 1);
  localparam int unsigned IW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [CW-1:0]    acc, acc_nxt;
  logic [CW-1:0]    count_nxt;
  logic             zero_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [3:0]       nib;

  // Leading zeros of a non-zero nibble.
  function automatic logic [1:0] lz4(input logic [3:0] n);
    logic [1:0] r;
    casez (n)
      4'b1???: r = 2'd0;
      4'b01??: r = 2'd1;
      4'b001?: r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sh    <= '0;
      idx   <= '0;
      acc   <= '0;
      count <= '0;
      zero  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      sh    <= sh_nxt;
      idx   <= idx_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      zero  <= zero_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    idx_nxt   = idx;
    acc_nxt   = acc;
    count_nxt = count;
    zero_nxt  = zero;
    nib       = sh[WIDTH-1 -: 4];

    case (state)
      IDLE: begin
        if (start) begin
          sh_nxt    = din;
          idx_nxt   = '0;
          acc_nxt   = '0;
          count_nxt = '0;
          zero_nxt  = 1'b0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (nib != 4'd0) begin
          count_nxt = acc + CW'(lz4(nib));
          zero_nxt  = 1'b0;
          state_nxt = DONE;
        end else if (idx != IW'(NIBBLES - 1)) begin
          // acc stays <= WIDTH-4 here, so the add cannot overflow CW bits.
          acc_nxt = acc + CW'(4);
          sh_nxt  = sh << 4;
          idx_nxt = idx + IW'(1);
        end else begin
          count_nxt = CW'(WIDTH);
          zero_nxt  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Flags are registered from the next state so they line up with it.
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

endmodule

// File: tb/tb_lzc_seq_ctrl.sv
// Testbench for lzc_seq_ctrl (NIBBLES=4). A timing model tracks the
// expected outputs every cycle; directed operations pin it with literals.
module tb_lzc_seq_ctrl;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;
  localparam int unsigned CW  = $clog2(W + 1);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  din;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
  logic          zero;

  int n_vec = 0;
  int n_err = 0;

  lzc_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .count (count),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clz(input logic [W-1:0] d);
    int n = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (d[i]) break;
      n++;
    end
    return n;
  endfunction

  // Model: remaining busy cycles after an accepted start; the result is
  // published in the final busy cycle.
  int m_left  = 0;
  int m_res   = 0;
  int m_count = 0;
  bit m_zero  = 0;
  bit m_valid = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left  = 0;
      m_count = 0;
      m_zero  = 0;
      m_valid = 1;
    end else if (m_left == 0) begin
      if (start) begin
        int lz;
        int k;
        lz      = clz(din);
        k       = (lz / 4 + 1 > NIB) ? NIB : lz / 4 + 1;
        m_res   = lz;
        m_left  = k + 1;
        m_count = 0;
        m_zero  = 0;
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        m_count = m_res;
        m_zero  = (m_res == W);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_busy",  int'(busy),  int'(m_left > 0));
      chk("model_done",  int'(done),  int'(m_left == 1));
      chk("model_count", int'(count), m_count);
      chk("model_zero",  int'(zero),  int'(m_zero));
    end
  end

  // Launch one operation and check latency, count and zero against literals.
  task automatic run_op(input logic [W-1:0] d, input int exp_count,
                        input int exp_zero, input int exp_k,
                        input logic [W-1:0] d_after);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    din   = d;
    @(negedge clk);
    start = 1'b0;
    din   = d_after;
    cyc   = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, exp_k + 1);
    chk("count", int'(count), exp_count);
    chk("zero", int'(zero), exp_zero);
    chk("busy_in_done", int'(busy), 1);
    @(negedge clk);
    chk("done_drop", int'(done), 0);
    chk("busy_drop", int'(busy), 0);
    chk("count_hold", int'(count), exp_count);
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0;
    start = 1'b1;
    din   = 16'h1234;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_zero", int'(zero), 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h8000, 0, 0, 1, 16'h8000);
    run_op(16'h0001, 15, 0, 4, 16'h0001);
    run_op(16'h00F0, 8, 0, 3, 16'h00F0);
    run_op(16'h0300, 6, 0, 2, 16'h0300);
    run_op(16'h0000, 16, 1, 4, 16'h0000);
    run_op(16'h4000, 1, 0, 1, 16'h4000);
    // din changes during SCAN must not matter
    run_op(16'h0001, 15, 0, 4, 16'hFFFF);

    // start held high: accepted every 6 cycles, one done per operation
    @(negedge clk);
    start = 1'b1;
    din   = 16'h0001;
    ndone = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    chk("held_start_dones", ndone, 3);
    chk("held_start_idle", int'(busy), 0);
    repeat (2) @(negedge clk);

    // reset at E2 aborts an all-zero scan
    start = 1'b1;
    din   = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_count", int'(count), 0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    chk("abort_no_done", ndone, 0);
    run_op(16'h2000, 2, 0, 1, 16'h2000);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
